// File: rtl/noc_local_injector_if.sv
// Core-request and router-link signal bundle for the local injector.
// The injector sits on the slave side; the core/router model drives the master side.
interface noc_local_injector_if;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_dest;
   logic [7:0]  req_payload;
   logic [15:0] data_o;
   logic        send_o;
   logic        credit_i;

   modport master (
      output req_valid, req_dest, req_payload, credit_i,
      input  req_ready, data_o, send_o
   );

   modport slave (
      input  req_valid, req_dest, req_payload, credit_i,
      output req_ready, data_o, send_o
   );
endinterface

// File: rtl/noc_local_injector.sv
// Local-port injection stage: buffers core requests in a small FIFO and sends
// single 16-bit flits to the router under credit flow control.
module noc_local_injector #(
   parameter int XCOORD    = 0,
   parameter int YCOORD    = 0,
   parameter int CREDITS   = 4,
   parameter int REQ_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   noc_local_injector_if.slave              bus,
   output logic [$clog2(CREDITS+1)-1:0]     credits_o,
   output logic [15:0]                      sent_count_o,
   output logic                             self_drop_o,
   output logic                             credit_err_o
);
   localparam int AW   = $clog2(REQ_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int CW   = $clog2(CREDITS + 1);
   localparam logic [CNTW-1:0] DEPTH_C     = CNTW'(REQ_DEPTH);
   localparam logic [CW-1:0]   CRED_MAX_C  = CW'(CREDITS);
   localparam logic [7:0]      SELF_ADDR_C = {4'(XCOORD), 4'(YCOORD)};

   logic [15:0]     mem_q [REQ_DEPTH];
   logic [15:0]     mem_d [REQ_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [CW-1:0]   credits_q, credits_d;
   logic            ready_q, ready_d;
   logic [15:0]     data_q, data_d;
   logic            send_q, send_d;
   logic [15:0]     sent_q, sent_d;
   logic            drop_q, drop_d;
   logic            err_q, err_d;

   logic            hs_s, self_s, push_s, fire_s;

   assign hs_s   = bus.req_valid & ready_q;
   assign self_s = (bus.req_dest == SELF_ADDR_C);
   assign push_s = hs_s & ~self_s;
   // Decision uses only registered count/credits, so a credit arriving this cycle waits a cycle.
   assign fire_s = (count_q != {CNTW{1'b0}}) & (credits_q != {CW{1'b0}});

   // Next-state for FIFO, credit counter and link outputs.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      credits_d = credits_q;
      err_d     = err_q;
      data_d    = data_q;
      send_d    = 1'b0;
      sent_d    = sent_q;
      drop_d    = hs_s & self_s;

      if (push_s) begin
         mem_d[wr_ptr_q] = {bus.req_payload, bus.req_dest};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (fire_s) begin
         data_d   = mem_q[rd_ptr_q];
         send_d   = 1'b1;
         rd_ptr_d = rd_ptr_q + AW'(1);
         sent_d   = sent_q + 16'd1;
      end else begin
         data_d = data_q;
      end

      case ({push_s, fire_s})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase

      case ({fire_s, bus.credit_i})
         2'b10:   credits_d = credits_q - CW'(1);
         2'b01: begin
            if (credits_q == CRED_MAX_C) begin
               credits_d = credits_q;
               err_d     = 1'b1;
            end else begin
               credits_d = credits_q + CW'(1);
            end
         end
         default: credits_d = credits_q;
      endcase

      ready_d = (count_d < DEPTH_C);
   end

   // State registers; reset drops every queued flit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REQ_DEPTH; i++) begin
            mem_q[i] <= 16'h0000;
         end
         wr_ptr_q  <= {AW{1'b0}};
         rd_ptr_q  <= {AW{1'b0}};
         count_q   <= {CNTW{1'b0}};
         credits_q <= CRED_MAX_C;
         ready_q   <= 1'b1;
         data_q    <= 16'h0000;
         send_q    <= 1'b0;
         sent_q    <= 16'h0000;
         drop_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         credits_q <= credits_d;
         ready_q   <= ready_d;
         data_q    <= data_d;
         send_q    <= send_d;
         sent_q    <= sent_d;
         drop_q    <= drop_d;
         err_q     <= err_d;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.data_o    = data_q;
   assign bus.send_o    = send_q;
   assign credits_o     = credits_q;
   assign sent_count_o  = sent_q;
   assign self_drop_o   = drop_q;
   assign credit_err_o  = err_q;
endmodule

// File: tb/tb_noc_local_injector.sv
// Directed table-driven bench for noc_local_injector at node (2,3), 4 credits, 4-entry FIFO.
module tb_noc_local_injector;
   logic        clk;
   logic        rst;
   logic [2:0]  credits_o;
   logic [15:0] sent_count_o;
   logic        self_drop_o;
   logic        credit_err_o;

   int n_tests;
   int n_fail;

   noc_local_injector_if u_if ();

   noc_local_injector #(
      .XCOORD(2), .YCOORD(3), .CREDITS(4), .REQ_DEPTH(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (u_if),
      .credits_o    (credits_o),
      .sent_count_o (sent_count_o),
      .self_drop_o  (self_drop_o),
      .credit_err_o (credit_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic [7:0]  p;
      logic        c;
      logic        e_send;
      logic [15:0] e_data;
      logic [2:0]  e_cr;
      logic        e_rdy;
      logic [15:0] e_sc;
      logic        e_drop;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic [7:0] p, input logic c,
                      input logic es, input logic [15:0] ed, input logic [2:0] ecr,
                      input logic erdy, input logic [15:0] esc, input logic edrop, input logic eerr);
      vec_t t;
      t.v = v; t.d = d; t.p = p; t.c = c;
      t.e_send = es; t.e_data = ed; t.e_cr = ecr; t.e_rdy = erdy;
      t.e_sc = esc; t.e_drop = edrop; t.e_err = eerr;
      tbl.push_back(t);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic [7:0] p, input logic c);
      u_if.req_valid   = v;
      u_if.req_dest    = d;
      u_if.req_payload = p;
      u_if.credit_i    = c;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_credits"}, 32'(credits_o), 32'd4);
      chk({tag, "_ready"},   32'(u_if.req_ready), 32'd1);
      chk({tag, "_send"},    32'(u_if.send_o), 32'd0);
      chk({tag, "_data"},    32'(u_if.data_o), 32'h0000);
      chk({tag, "_sent"},    32'(sent_count_o), 32'd0);
      chk({tag, "_drop"},    32'(self_drop_o), 32'd0);
      chk({tag, "_err"},     32'(credit_err_o), 32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      drive(1'b0, 8'h00, 8'h00, 1'b0);

      //    v     dest   pay    crd  | send  data      cr    rdy   sent    drop  err
      add(1'b0+1'b1, 8'h21, 8'hA5, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b1, 16'd0,  1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'hA521, 3'd3, 1'b1, 16'd1,  1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'hA521, 3'd4, 1'b1, 16'd1,  1'b0, 1'b0);
      add(1'b1, 8'h45, 8'h10, 1'b0, 1'b0, 16'hA521, 3'd4, 1'b1, 16'd1,  1'b0, 1'b0);
      add(1'b1, 8'h45, 8'h11, 1'b0, 1'b1, 16'h1045, 3'd3, 1'b1, 16'd2,  1'b0, 1'b0);
      add(1'b1, 8'h45, 8'h12, 1'b0, 1'b1, 16'h1145, 3'd2, 1'b1, 16'd3,  1'b0, 1'b0);
      add(1'b1, 8'h45, 8'h13, 1'b0, 1'b1, 16'h1245, 3'd1, 1'b1, 16'd4,  1'b0, 1'b0);
      add(1'b1, 8'h45, 8'h14, 1'b0, 1'b1, 16'h1345, 3'd0, 1'b1, 16'd5,  1'b0, 1'b0);
      add(1'b1, 8'h45, 8'h15, 1'b0, 1'b0, 16'h1345, 3'd0, 1'b1, 16'd5,  1'b0, 1'b0);
      add(1'b1, 8'h45, 8'h16, 1'b0, 1'b0, 16'h1345, 3'd0, 1'b1, 16'd5,  1'b0, 1'b0);
      add(1'b1, 8'h45, 8'h17, 1'b0, 1'b0, 16'h1345, 3'd0, 1'b0, 16'd5,  1'b0, 1'b0);
      // Full FIFO: this request must be refused; the credit is not usable until next cycle.
      add(1'b1, 8'h45, 8'h18, 1'b1, 1'b0, 16'h1345, 3'd1, 1'b0, 16'd5,  1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h1445, 3'd0, 1'b1, 16'd6,  1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h1445, 3'd0, 1'b1, 16'd6,  1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h1445, 3'd1, 1'b1, 16'd6,  1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h1545, 3'd1, 1'b1, 16'd7,  1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h1645, 3'd1, 1'b1, 16'd8,  1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h1745, 3'd1, 1'b1, 16'd9,  1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h1745, 3'd2, 1'b1, 16'd9,  1'b0, 1'b0);
      add(1'b1, 8'h21, 8'h5A, 1'b0, 1'b0, 16'h1745, 3'd2, 1'b1, 16'd9,  1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h5A21, 3'd2, 1'b1, 16'd10, 1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h5A21, 3'd3, 1'b1, 16'd10, 1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h5A21, 3'd4, 1'b1, 16'd10, 1'b0, 1'b0);
      add(1'b1, 8'h23, 8'h77, 1'b0, 1'b0, 16'h5A21, 3'd4, 1'b1, 16'd10, 1'b1, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h5A21, 3'd4, 1'b1, 16'd10, 1'b0, 1'b0);
      add(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h5A21, 3'd4, 1'b1, 16'd10, 1'b0, 1'b1);
      add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h5A21, 3'd4, 1'b1, 16'd10, 1'b0, 1'b1);

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals("reset_release");
      @(posedge clk);
      #1 check_reset_vals("reset_idle");

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].c);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_send", i),    32'(u_if.send_o),    32'(tbl[i].e_send));
         chk($sformatf("v%0d_data", i),    32'(u_if.data_o),    32'(tbl[i].e_data));
         chk($sformatf("v%0d_credits", i), 32'(credits_o),      32'(tbl[i].e_cr));
         chk($sformatf("v%0d_ready", i),   32'(u_if.req_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("v%0d_sent", i),    32'(sent_count_o),   32'(tbl[i].e_sc));
         chk($sformatf("v%0d_drop", i),    32'(self_drop_o),    32'(tbl[i].e_drop));
         chk($sformatf("v%0d_err", i),     32'(credit_err_o),   32'(tbl[i].e_err));
      end

      // Seven back-to-back requests: four go out, three stay queued with no credits left.
      for (int k = 0; k < 7; k++) begin
         drive(1'b1, 8'h45, 8'h20 + 8'(k), 1'b0);
         @(posedge clk);
         #1;
      end
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      chk("preq_credits", 32'(credits_o), 32'd0);
      chk("preq_sent", 32'(sent_count_o), 32'd14);
      chk("preq_data", 32'(u_if.data_o), 32'h2345);
      chk("preq_err_sticky", 32'(credit_err_o), 32'd1);

      // Asynchronous reset mid-cycle, away from any clock edge.
      #2 rst = 1'b0;
      #1 check_reset_vals("async_reset");
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1 chk($sformatf("post_reset_send%0d", k), 32'(u_if.send_o), 32'd0);
      end
      chk("post_reset_sent", 32'(sent_count_o), 32'd0);
      chk("post_reset_credits", 32'(credits_o), 32'd4);
      chk("post_reset_ready", 32'(u_if.req_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/noc_local_injector.md
Name: noc_local_injector

Overview:
- Network-interface injection stage between a processing core and a router's local input port (L_ifc_b).
- Accepts core requests (destination coordinates + 8-bit payload) on a valid/ready handshake and buffers them in a small FIFO.
- Forms single 16-bit flits and drives them onto the credit-flow-controlled link (data/enable out, credit back in).
- Tracks downstream buffer credits and discards self-addressed requests.

Parameters:
- XCOORD, 0, this node's X coordinate (4 bits used).
- YCOORD, 0, this node's Y coordinate (4 bits used).
- CREDITS, 4, downstream input-port buffer depth; initial credit count.
- REQ_DEPTH, 4, internal request FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- req_valid  in  1  core request valid.
- req_ready  out  1  injector can accept a request.
- req_dest  in  8  destination {x[3:0], y[3:0]}.
- req_payload  in  8  payload byte.
- data_o  out  16  flit to router local input; {payload[7:0], dest[7:0]}.
- send_o  out  1  flit valid on data_o (write enable into router buffer).
- credit_i  in  1  one-cycle pulse: router freed one buffer slot.
- credits_o  out  $clog2(CREDITS+1)  current credit count.
- sent_count_o  out  16  flits sent since reset.
- self_drop_o  out  1  one-cycle pulse: self-addressed request discarded.
- credit_err_o  out  1  sticky: credit received while counter at CREDITS.

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied, pointers 0.
  - credits_o=CREDITS.
  - data_o=0, send_o=0, sent_count_o=0, self_drop_o=0, credit_err_o=0.
  - Reset mid-transfer discards all queued flits; no partial send survives.
- Accept:
  - req_ready = (fifo_count < REQ_DEPTH), registered state only; no same-cycle pop bypass. A full FIFO is not ready even in a pop cycle.
  - Handshake = req_valid & req_ready.
- Self-address:
  - If req_dest == {XCOORD[3:0], YCOORD[3:0]} on handshake, the request is consumed but not enqueued.
  - self_drop_o pulses in the next cycle.
- Enqueue: otherwise write {req_payload, req_dest} at wr_ptr; wr_ptr wraps modulo REQ_DEPTH.
- Send decision (each cycle): fire = fifo_nonempty & (credits > 0).
  - On fire, the head is popped; data_o <= head and send_o <= 1 at the same edge.
  - Otherwise send_o <= 0 and data_o holds its last value.
  - At most one flit per cycle.
- Latency: handshake in cycle c gives send_o=1 in cycle c+2 at the earliest (empty FIFO, credits available).
- Simultaneous push and pop: both occur; count unchanged.
- Credit counter: next = credits - fire + credit_i.
  - fire and credit_i in the same cycle: value unchanged.
  - credit_i in cycle t is not usable for a fire decision until cycle t+1.
  - credits==0 blocks fire; the head stays queued until a credit arrives.
  - credit_i while credits==CREDITS and no fire: counter saturates at CREDITS and credit_err_o sets (cleared only by reset).
- sent_count_o increments on each fire and wraps 16'hFFFF->0.
- Ordering: strict FIFO; flits leave in acceptance order.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release -> credits_o=4, req_ready=1, send_o=0, data_o=0, sent_count_o=0.
- Single send: req_dest=8'h21, req_payload=8'hA5, one handshake in cycle c -> send_o=1 only in c+2, data_o=16'hA521, credits_o=3, sent_count_o=1.
- Credit exhaustion and FIFO full:
  - 8 back-to-back requests, no credit_i -> exactly 4 sends; credits_o=0.
  - req_ready=0 once 4 remain queued.
  - One credit_i pulse -> exactly one further send the cycle after next.
- Simultaneous credit and fire: credits_o=2, FIFO nonempty, credit_i=1 -> credits_o stays 2 and a flit is sent.
- Self-address (XCOORD=2, YCOORD=3): request dest 8'h23 -> consumed, self_drop_o one-cycle pulse, no send_o, credits unchanged.
- Error and reset: credit_i while credits_o=4 -> credit_err_o=1 and stays 1; assert rst with 3 flits queued -> outputs return to reset values asynchronously, and after release no stale flit is sent.
